// File: rtl/round_judge.sv
// Memory-tile round judge: shows a 4x4 board, then scores tile guesses until win or out of lives.
// Optional build macro MISS_MASK_EN tracks wrong tiles so a repeated miss costs no extra life.
module round_judge #(
  parameter int REVEAL_CYCLES = 50000000,
  parameter int LIVES         = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_board_valid,
  input  logic [15:0] i_board,
  input  logic        i_guess_valid,
  input  logic [3:0]  i_guess_idx,
  output logic [15:0] o_display,
  output logic [15:0] o_found,
  output logic [15:0] o_missed,
  output logic [1:0]  o_lives_left,
  output logic [2:0]  o_state,
  output logic        o_win,
  output logic        o_lose
);

  // state  | meaning
  // IDLE   | waiting for the first board after reset
  // REVEAL | target shown, reveal timer counting down
  // PLAY   | accepting guesses, display shows found|missed
  // WIN    | every target tile found, target shown
  // LOSE   | lives exhausted, target shown
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REVEAL = 3'd1,
    S_PLAY   = 3'd2,
    S_WIN    = 3'd3,
    S_LOSE   = 3'd4
  } state_t;

  localparam int             TW         = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam logic [TW-1:0]  TIMER_LOAD = TW'(REVEAL_CYCLES - 1);
  localparam logic [1:0]     LIVES_LOAD = 2'(LIVES);

  state_t        r_state;
  logic [15:0]   r_target;
  logic [15:0]   r_found;
  logic [15:0]   r_missed;
  logic [1:0]    r_lives;
  logic [TW-1:0] r_timer;
  logic [15:0]   r_display;
  logic          r_win;
  logic          r_lose;

  state_t        w_state_nxt;
  logic [15:0]   w_target_nxt;
  logic [15:0]   w_found_nxt;
  logic [15:0]   w_missed_nxt;
  logic [1:0]    w_lives_nxt;
  logic [TW-1:0] w_timer_nxt;
  logic [15:0]   w_display_nxt;
  logic [15:0]   w_guess_bit;

  assign w_guess_bit = 16'd1 << i_guess_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_target  <= '0;
      r_found   <= '0;
      r_missed  <= '0;
      r_lives   <= '0;
      r_timer   <= '0;
      r_display <= '0;
      r_win     <= 1'b0;
      r_lose    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_target  <= w_target_nxt;
      r_found   <= w_found_nxt;
      r_missed  <= w_missed_nxt;
      r_lives   <= w_lives_nxt;
      r_timer   <= w_timer_nxt;
      r_display <= w_display_nxt;
      r_win     <= (w_state_nxt == S_WIN);
      r_lose    <= (w_state_nxt == S_LOSE);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_found_nxt  = r_found;
    w_missed_nxt = r_missed;
    w_lives_nxt  = r_lives;
    w_timer_nxt  = r_timer;

    case (r_state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (i_board_valid) begin
          w_target_nxt = i_board;
          w_found_nxt  = '0;
          w_missed_nxt = '0;
          w_lives_nxt  = LIVES_LOAD;
          w_timer_nxt  = TIMER_LOAD;
          w_state_nxt  = S_REVEAL;
        end
      end
      S_REVEAL: begin
        if (r_timer == '0) w_state_nxt = S_PLAY;
        else               w_timer_nxt = r_timer - TW'(1);
      end
      S_PLAY: begin
        if (i_guess_valid) begin
          if (r_target[i_guess_idx]) begin
            w_found_nxt = r_found | w_guess_bit;
          end else begin
`ifdef MISS_MASK_EN
            if (!r_missed[i_guess_idx]) begin
              w_missed_nxt = r_missed | w_guess_bit;
              if (r_lives != 2'd0) w_lives_nxt = r_lives - 2'd1;
            end
`else
            if (r_lives != 2'd0) w_lives_nxt = r_lives - 2'd1;
`endif
          end
        end
        // An empty target also satisfies this on the first PLAY cycle.
        if (w_found_nxt == r_target)  w_state_nxt = S_WIN;
        else if (w_lives_nxt == 2'd0) w_state_nxt = S_LOSE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_REVEAL, S_WIN, S_LOSE: w_display_nxt = w_target_nxt;
      S_PLAY:                  w_display_nxt = w_found_nxt | w_missed_nxt;
      default:                 w_display_nxt = '0;
    endcase
  end

  assign o_display    = r_display;
  assign o_found      = r_found;
  assign o_missed     = r_missed;
  assign o_lives_left = r_lives;
  assign o_state      = r_state;
  assign o_win        = r_win;
  assign o_lose       = r_lose;

endmodule

// File: tb/tb_round_judge.sv
// Directed table-driven bench for round_judge with a short reveal window (4 cycles).
module tb_round_judge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        board_valid;
  logic [15:0] board;
  logic        guess_valid;
  logic [3:0]  guess_idx;
  logic [15:0] display, found, missed;
  logic [1:0]  lives_left;
  logic [2:0]  state;
  logic        win, lose;

  int total = 0;
  int bad   = 0;

  round_judge #(.REVEAL_CYCLES(4), .LIVES(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_board_valid(board_valid), .i_board(board),
    .i_guess_valid(guess_valid), .i_guess_idx(guess_idx),
    .o_display(display), .o_found(found), .o_missed(missed),
    .o_lives_left(lives_left), .o_state(state), .o_win(win), .o_lose(lose)
  );

  always #5 clk = ~clk;

`ifdef MISS_MASK_EN
  localparam logic [15:0] M1 = 16'h0002, M2 = 16'h0006, M3 = 16'h000e;
  localparam logic [1:0]  LREP = 2'd2;
`else
  localparam logic [15:0] M1 = 16'h0000, M2 = 16'h0000, M3 = 16'h0000;
  localparam logic [1:0]  LREP = 2'd1;
`endif

  typedef struct {
    logic        bv;
    logic [15:0] bd;
    logic        gv;
    logic [3:0]  gi;
    logic [2:0]  st;
    logic [15:0] disp;
    logic [15:0] fnd;
    logic [15:0] mis;
    logic [1:0]  lv;
    logic        w;
    logic        l;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic bv, logic [15:0] bd, logic gv, logic [3:0] gi,
                              logic [2:0] st, logic [15:0] disp, logic [15:0] fnd,
                              logic [15:0] mis, logic [1:0] lv, logic w, logic l);
    vec_t v;
    v.bv = bv; v.bd = bd; v.gv = gv; v.gi = gi;
    v.st = st; v.disp = disp; v.fnd = fnd; v.mis = mis; v.lv = lv; v.w = w; v.l = l;
    return v;
  endfunction

  task automatic cmp(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
    end
  endtask

  task automatic check_all(input int row, input logic [2:0] st, input logic [15:0] disp,
                           input logic [15:0] fnd, input logic [15:0] mis, input logic [1:0] lv,
                           input logic w, input logic l);
    cmp("state",   row, 16'(state),      16'(st));
    cmp("display", row, display,         disp);
    cmp("found",   row, found,           fnd);
    cmp("missed",  row, missed,          mis);
    cmp("lives",   row, 16'(lives_left), 16'(lv));
    cmp("win",     row, 16'(win),        16'(w));
    cmp("lose",    row, 16'(lose),       16'(l));
  endtask

  initial begin
    rst_n = 1'b0; board_valid = 1'b0; board = '0; guess_valid = 1'b0; guess_idx = '0;

    // guess in IDLE ignored
    vecs.push_back(mk(0, 16'h0000, 1, 4'd5,  3'd0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0, 0));
    // reveal window of exactly 4 cycles, then PLAY
    vecs.push_back(mk(1, 16'h8001, 0, 4'd0,  3'd1, 16'h8001, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 4'd0,  3'd1, 16'h8001, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 4'd0,  3'd1, 16'h8001, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 4'd0,  3'd1, 16'h8001, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 4'd0,  3'd2, 16'h0000, 16'h0000, 16'h0000, 2'd3, 0, 0));
    // hits, repeat hit, win
    vecs.push_back(mk(0, 16'h0000, 1, 4'd0,  3'd2, 16'h0001, 16'h0001, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 4'd0,  3'd2, 16'h0001, 16'h0001, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 4'd15, 3'd3, 16'h8001, 16'h8001, 16'h0000, 2'd3, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 4'd3,  3'd3, 16'h8001, 16'h8001, 16'h0000, 2'd3, 1, 0));
    // new round, three misses -> LOSE
    vecs.push_back(mk(1, 16'h8001, 0, 4'd0,  3'd1, 16'h8001, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 4'd0,  3'd1, 16'h8001, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 4'd0,  3'd1, 16'h8001, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 4'd0,  3'd1, 16'h8001, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 4'd0,  3'd2, 16'h0000, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 4'd1,  3'd2, M1,       16'h0000, M1,       2'd2, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 4'd2,  3'd2, M2,       16'h0000, M2,       2'd1, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 4'd3,  3'd4, 16'h8001, 16'h0000, M3,       2'd0, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 4'd4,  3'd4, 16'h8001, 16'h0000, M3,       2'd0, 0, 1));
    // empty board: board_valid and guesses in REVEAL ignored, WIN right after first PLAY cycle
    vecs.push_back(mk(1, 16'h0000, 0, 4'd0,  3'd1, 16'h0000, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(1, 16'hffff, 0, 4'd0,  3'd1, 16'h0000, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 4'd5,  3'd1, 16'h0000, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 4'd0,  3'd1, 16'h0000, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 4'd0,  3'd2, 16'h0000, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 4'd0,  3'd3, 16'h0000, 16'h0000, 16'h0000, 2'd3, 1, 0));
    // repeated wrong guess on the same tile
    vecs.push_back(mk(1, 16'h8001, 0, 4'd0,  3'd1, 16'h8001, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 4'd0,  3'd1, 16'h8001, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 4'd0,  3'd1, 16'h8001, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 4'd0,  3'd1, 16'h8001, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 4'd0,  3'd2, 16'h0000, 16'h0000, 16'h0000, 2'd3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 4'd1,  3'd2, M1,       16'h0000, M1,       2'd2, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 4'd1,  3'd2, M1,       16'h0000, M1,       LREP, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    check_all(-1, 3'd0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      board_valid = vecs[i].bv; board = vecs[i].bd;
      guess_valid = vecs[i].gv; guess_idx = vecs[i].gi;
      @(posedge clk);
      #1;
      check_all(i, vecs[i].st, vecs[i].disp, vecs[i].fnd, vecs[i].mis, vecs[i].lv, vecs[i].w, vecs[i].l);
    end
    board_valid = 1'b0; guess_valid = 1'b0;

    // asynchronous reset in the middle of PLAY
    #3;
    rst_n = 1'b0;
    #1;
    check_all(100, 3'd0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0, 0);
    // board_valid while reset is held must not start a round
    board_valid = 1'b1; board = 16'h0f0f;
    @(posedge clk);
    #1;
    check_all(101, 3'd0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all(102, 3'd1, 16'h0f0f, 16'h0000, 16'h0000, 2'd3, 0, 0);
    board_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_judge.md
ROUND_JUDGE -- requirements
Module: round_judge

Interface
REQ-001 Parameter: REVEAL_CYCLES, 50000000, clock cycles the board is shown before play (>=1).
REQ-002 Parameter: LIVES, 3, wrong guesses allowed per round (1..3).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 board_valid  input  1  one-cycle pulse; board holds a new pattern to play.
REQ-006 board  input  16  4x4 target pattern; bit i = tile i lit.
REQ-007 guess_valid  input  1  one-cycle pulse; player selected tile guess_idx.
REQ-008 guess_idx  input  4  selected tile index, 0..15.
REQ-009 display  output  16  tiles to light on screen.
REQ-010 found  output  16  target tiles correctly guessed this round.
REQ-011 missed  output  16  non-target tiles guessed this round (see Configuration).
REQ-012 lives_left  output  2  remaining lives.
REQ-013 state  output  3  current FSM state encoding, for display/debug.
REQ-014 win  output  1  high while in WIN.
REQ-015 lose  output  1  high while in LOSE.

Function
REQ-016 FSM states SHALL be IDLE=0, REVEAL=1, PLAY=2, WIN=3, LOSE=4; all outputs registered.
REQ-017 IDLE/WIN/LOSE + board_valid: latch board into target, clear found and missed, lives_left<=LIVES, timer<=REVEAL_CYCLES-1, go REVEAL next edge.
REQ-018 board_valid in REVEAL or PLAY SHALL be ignored (no restart mid-round).
REQ-019 REVEAL: display=target; timer decrements each cycle; on edge where timer==0 go PLAY; REVEAL lasts exactly REVEAL_CYCLES cycles.
REQ-020 guess_valid outside PLAY SHALL be ignored, no state change.
REQ-021 PLAY: display=found|missed; on guess_valid with target[guess_idx]=1 and found bit clear, set found[guess_idx] at that edge.
REQ-022 Guess of an already-found tile SHALL have no effect.
REQ-023 Guess with target[guess_idx]=0 SHALL decrement lives_left by 1 at that edge; if result is 0, go LOSE same edge.
REQ-024 If (found | newly set bit) == target, go WIN at the same edge the last bit is set; win high the following cycle.
REQ-025 target==0: on first PLAY cycle go WIN without any guess.
REQ-026 lives_left SHALL never underflow; it saturates at 0.
REQ-027 WIN/LOSE: display=target; found, missed, lives_left frozen until next board_valid.
REQ-028 win and lose SHALL never be high together; both low outside WIN/LOSE.

Reset
REQ-029 reset low SHALL asynchronously force state=IDLE, target=0, found=0, missed=0, lives_left=0, timer=0, display=0, win=0, lose=0.
REQ-030 Reset asserted mid-round SHALL abandon the round; after release block waits in IDLE for board_valid.
REQ-031 First board_valid accepted at the first rising edge after reset deasserts.

Configuration
REQ-032 Macro MISS_MASK_EN defined: wrong guess sets missed[guess_idx]; repeat wrong guess on a tile already in missed costs no life.
REQ-033 MISS_MASK_EN undefined: missed SHALL be constant 0 and every wrong guess costs one life, including repeats.

Verification
REQ-034 REVEAL_CYCLES=4, board=16'h8001 pulse -> display=16'h8001 for exactly 4 cycles, then PLAY with display=0, lives_left=3.
REQ-035 PLAY, guesses 0 then 15 -> found=16'h0001 then 16'h8001, state=WIN, win=1 next cycle, display=16'h8001.
REQ-036 board=16'h8001, guesses 1,2,3 -> lives_left 2,1,0; LOSE entered on third guess edge; lose=1.
REQ-037 With MISS_MASK_EN, guess 1 twice -> missed=16'h0002, lives_left=2; without macro -> missed=0, lives_left=1.
REQ-038 board=0 -> WIN one cycle after REVEAL ends; board_valid during REVEAL ignored; reset pulse during PLAY -> all outputs 0, state=IDLE.
